// File: rtl/brch_pkg.sv
// Shared encodings for the branch resolution / prediction unit:
// condition codes, ex_brch_instr bit positions and 2-bit counter states.
package brch_pkg;

    localparam logic [1:0] COND_EQZ = 2'b00;
    localparam logic [1:0] COND_NEZ = 2'b01;
    localparam logic [1:0] COND_LTZ = 2'b10;
    localparam logic [1:0] COND_GEZ = 2'b11;

    localparam int BRCH_JMP = 3;
    localparam int BRCH_CND = 2;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // One training step of a 2-bit counter, saturating at SNT and ST.
    function automatic logic [1:0] sat_step(input logic [1:0] cur, input logic up);
        logic [1:0] nxt;
        nxt = cur;
        if (up && cur != ST)
            nxt = cur + 2'b01;
        else if (!up && cur != SNT)
            nxt = cur - 2'b01;
        return nxt;
    endfunction

endpackage

// File: rtl/sat_cnt2.sv
// One 2-bit saturating direction counter; resets to weak-not-taken.
module sat_cnt2
    import brch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    output logic [1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= WNT;
        else if (en)
            q <= sat_step(q, up);
    end

endmodule

// File: rtl/brch_predict_unit.sv
// Execute-stage branch resolution with a PC-indexed table of 2-bit counters
// feeding fetch predictions, plus a registered flush/redirect on mispredict.
module brch_predict_unit
    import brch_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int PC_W        = 16,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [3:0]        ex_brch_instr,
    input  logic [DATA_W-1:0] ex_rs_val,
    input  logic              ex_pred_taken,
    input  logic [PC_W-1:0]   ex_target,
    input  logic [PC_W-1:0]   ex_pc_plus2,
    output logic              BrchCnd,
    output logic              flush,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [CNT_W-1:0]  brch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             is_jmp;
    logic             is_cnd;
    logic             cond;
    logic             resolve;
    logic             mispredict;
    logic             bht_upd;

    // Bit 0 of the PC is always zero for halfword-aligned instructions.
    assign if_idx        = if_pc[IDX_W:1];
    assign ex_idx        = ex_pc[IDX_W:1];
    assign if_pred_taken = bht[if_idx][1];

    assign is_jmp = ex_brch_instr[BRCH_JMP];
    assign is_cnd = ex_brch_instr[BRCH_CND];

    always_comb begin
        cond = 1'b0;
        case (ex_brch_instr[1:0])
            COND_EQZ: cond = (ex_rs_val == '0);
            COND_NEZ: cond = (ex_rs_val != '0);
            COND_LTZ: cond = ex_rs_val[DATA_W-1];
            COND_GEZ: cond = ~ex_rs_val[DATA_W-1];
            default:  cond = 1'b0;
        endcase
    end

    assign BrchCnd = is_jmp ? 1'b1 : (is_cnd ? cond : 1'b0);

    // ex_valid qualifies every ex_* input; ex_stall freezes them. An
    // instruction resolves in exactly the one cycle where ex_valid & ~ex_stall.
    assign resolve    = ex_valid & ~ex_stall & (is_jmp | is_cnd);
    assign mispredict = resolve & (BrchCnd != ex_pred_taken);
    assign bht_upd    = resolve & is_cnd & ~is_jmp;

    for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
        sat_cnt2 u_cnt (
            .clk (clk),
            .rst (rst),
            .en  (bht_upd && (ex_idx == IDX_W'(i))),
            .up  (BrchCnd),
            .q   (bht[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush       <= 1'b0;
            redirect_pc <= '0;
            brch_cnt    <= '0;
            mispred_cnt <= '0;
        end else begin
            flush <= mispredict;
            if (mispredict)
                redirect_pc <= BrchCnd ? ex_target : ex_pc_plus2;
            if (resolve && brch_cnt != '1)
                brch_cnt <= brch_cnt + CNT_W'(1);
            if (mispredict && mispred_cnt != '1)
                mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_brch_predict_unit.sv
// Bench for brch_predict_unit: vector table plus hand sequences, with a
// behavioural reference model feeding an expected-result queue.
module tb_brch_predict_unit;

    localparam int EW = 1 + 16 + 16 + 16 + 2 + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_stall;
    logic [15:0] ex_pc;
    logic [3:0]  ex_brch_instr;
    logic [15:0] ex_rs_val;
    logic        ex_pred_taken;
    logic [15:0] ex_target;
    logic [15:0] ex_pc_plus2;
    logic        BrchCnd;
    logic        flush;
    logic [15:0] redirect_pc;
    logic [15:0] brch_cnt;
    logic [15:0] mispred_cnt;

    logic        if_pred_taken2;
    logic        brch_cnd2;
    logic        flush2;
    logic [15:0] redirect_pc2;
    logic [1:0]  brch_cnt2;
    logic [1:0]  mispred_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    brch_predict_unit #(.DATA_W(16), .PC_W(16), .BHT_ENTRIES(16), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc),
        .ex_brch_instr(ex_brch_instr), .ex_rs_val(ex_rs_val),
        .ex_pred_taken(ex_pred_taken), .ex_target(ex_target),
        .ex_pc_plus2(ex_pc_plus2), .BrchCnd(BrchCnd), .flush(flush),
        .redirect_pc(redirect_pc), .brch_cnt(brch_cnt), .mispred_cnt(mispred_cnt)
    );

    brch_predict_unit #(.DATA_W(16), .PC_W(16), .BHT_ENTRIES(16), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .if_pc(if_pc), .if_pred_taken(if_pred_taken2),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_pc(ex_pc),
        .ex_brch_instr(ex_brch_instr), .ex_rs_val(ex_rs_val),
        .ex_pred_taken(ex_pred_taken), .ex_target(ex_target),
        .ex_pc_plus2(ex_pc_plus2), .BrchCnd(brch_cnd2), .flush(flush2),
        .redirect_pc(redirect_pc2), .brch_cnt(brch_cnt2), .mispred_cnt(mispred_cnt2)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic        stall;
        logic [15:0] pc;
        logic [3:0]  instr;
        logic [15:0] rs;
        logic        pred;
        logic [15:0] target;
        logic [15:0] pc2;
        logic [15:0] ifp;
        logic        exp_cnd;
    } vec_t;

    // Reference model state
    logic [1:0]    bht_m [16];
    logic          flush_m;
    logic [15:0]   red_m;
    logic [15:0]   brch_m;
    logic [15:0]   mis_m;
    logic [1:0]    brch2_m;
    logic [1:0]    mis2_m;
    logic [EW-1:0] exp_q [$];
    vec_t          vecs [$];

    function automatic vec_t mk(string n, logic v, logic s, logic [15:0] pc,
                                logic [3:0] ins, logic [15:0] rs, logic pr,
                                logic [15:0] tg, logic [15:0] p2,
                                logic [15:0] ifp, logic ec);
        vec_t r;
        r.name = n; r.valid = v; r.stall = s; r.pc = pc; r.instr = ins;
        r.rs = rs; r.pred = pr; r.target = tg; r.pc2 = p2; r.ifp = ifp;
        r.exp_cnd = ec;
        return r;
    endfunction

    function automatic vec_t idle(logic [15:0] ifp);
        return mk("idle", 1'b0, 1'b0, 16'h0, 4'b0000, 16'h0, 1'b0, 16'h0, 16'h0, ifp, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
        flush_m = 1'b0; red_m = '0; brch_m = '0; mis_m = '0;
        brch2_m = '0; mis2_m = '0;
        exp_q.delete();
    endtask

    task automatic drive_idle();
        ex_valid = 1'b0; ex_stall = 1'b0; ex_pc = '0; ex_brch_instr = '0;
        ex_rs_val = '0; ex_pred_taken = 1'b0; ex_target = '0; ex_pc_plus2 = '0;
    endtask

    // Reset held for two edges while a mispredicting branch sits in execute.
    task automatic do_reset();
        rst = 1'b1;
        ex_valid = 1'b1; ex_stall = 1'b0; ex_pc = 16'h0010; ex_brch_instr = 4'b0100;
        ex_rs_val = 16'h0000; ex_pred_taken = 1'b0; ex_target = 16'h0040;
        ex_pc_plus2 = 16'h0012; if_pc = 16'h0010;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive_idle();
        model_reset();
        chk("rst_flush", {31'b0, flush}, 32'd0);
        chk("rst_redirect", {16'b0, redirect_pc}, 32'd0);
        chk("rst_brch_cnt", {16'b0, brch_cnt}, 32'd0);
        chk("rst_mispred_cnt", {16'b0, mispred_cnt}, 32'd0);
        chk("rst_brch_cnt2", {30'b0, brch_cnt2}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            if_pc = 16'(i * 2);
            #1;
            chk($sformatf("rst_pred_idx%0d", i), {31'b0, if_pred_taken}, 32'd0);
        end
    endtask

    task automatic step(input vec_t v);
        logic          res;
        logic          mis;
        logic [3:0]    ix;
        logic [EW-1:0] e;
        ex_valid = v.valid; ex_stall = v.stall; ex_pc = v.pc; ex_brch_instr = v.instr;
        ex_rs_val = v.rs; ex_pred_taken = v.pred; ex_target = v.target;
        ex_pc_plus2 = v.pc2; if_pc = v.ifp;
        #1;
        chk({v.name, ":cnd"}, {31'b0, BrchCnd}, {31'b0, v.exp_cnd});
        chk({v.name, ":pred"}, {31'b0, if_pred_taken}, {31'b0, bht_m[v.ifp[4:1]][1]});
        res = v.valid && !v.stall && (v.instr[3] || v.instr[2]);
        mis = res && (v.exp_cnd != v.pred);
        if (res && v.instr[2] && !v.instr[3]) begin
            ix = v.pc[4:1];
            if (v.exp_cnd && bht_m[ix] != 2'b11) bht_m[ix] = bht_m[ix] + 2'b01;
            else if (!v.exp_cnd && bht_m[ix] != 2'b00) bht_m[ix] = bht_m[ix] - 2'b01;
        end
        if (res && brch_m != 16'hFFFF) brch_m = brch_m + 16'd1;
        if (mis && mis_m != 16'hFFFF) mis_m = mis_m + 16'd1;
        if (res && brch2_m != 2'b11) brch2_m = brch2_m + 2'd1;
        if (mis && mis2_m != 2'b11) mis2_m = mis2_m + 2'd1;
        flush_m = mis;
        if (mis) red_m = v.exp_cnd ? v.target : v.pc2;
        exp_q.push_back({flush_m, red_m, brch_m, mis_m, brch2_m, mis2_m});
        @(posedge clk); #1;
        if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s: expected queue empty", v.name);
        end else begin
            e = exp_q.pop_front();
            chk({v.name, ":flush"}, {31'b0, flush}, {31'b0, e[52]});
            if (e[52])
                chk({v.name, ":redirect"}, {16'b0, redirect_pc}, {16'b0, e[51:36]});
            chk({v.name, ":brch_cnt"}, {16'b0, brch_cnt}, {16'b0, e[35:20]});
            chk({v.name, ":mispred_cnt"}, {16'b0, mispred_cnt}, {16'b0, e[19:4]});
            chk({v.name, ":brch_cnt2"}, {30'b0, brch_cnt2}, {30'b0, e[3:2]});
            chk({v.name, ":mispred_cnt2"}, {30'b0, mispred_cnt2}, {30'b0, e[1:0]});
        end
    endtask

    initial begin
        rst = 1'b1;
        if_pc = '0;
        drive_idle();
        model_reset();
        do_reset();

        // Vector table: name, valid, stall, pc, instr, rs, pred, target, pc+2, if_pc, exp BrchCnd
        vecs.push_back(mk("beqz_mis",   1, 0, 16'h0010, 4'b0100, 16'h0000, 0, 16'h0040, 16'h0012, 16'h0010, 1));
        vecs.push_back(mk("inval_cnd",  0, 0, 16'h0010, 4'b0100, 16'h0005, 0, 16'h0040, 16'h0012, 16'h0010, 0));
        vecs.push_back(mk("bltz_neg",   1, 0, 16'h0020, 4'b0110, 16'h8000, 1, 16'h0060, 16'h0022, 16'h0020, 1));
        vecs.push_back(mk("bgez_pos",   1, 0, 16'h0022, 4'b0111, 16'h7FFF, 1, 16'h0070, 16'h0024, 16'h0022, 1));
        vecs.push_back(mk("bnez_mis",   1, 0, 16'h0024, 4'b0101, 16'h0000, 1, 16'h0080, 16'h0026, 16'h0024, 0));
        vecs.push_back(mk("bltz_b2b",   1, 0, 16'h0026, 4'b0110, 16'h0001, 1, 16'h0090, 16'h0028, 16'h0026, 0));
        vecs.push_back(mk("jmp_mis",    1, 0, 16'h000A, 4'b1000, 16'h0000, 0, 16'h0100, 16'h000C, 16'h000A, 1));
        vecs.push_back(idle(16'h000A));
        vecs.push_back(mk("jmp_prio",   1, 0, 16'h000C, 4'b1101, 16'h0000, 1, 16'h0110, 16'h000E, 16'h000C, 1));
        vecs.push_back(idle(16'h000C));
        vecs.push_back(mk("bgez_zero",  1, 0, 16'h002E, 4'b0111, 16'h0000, 0, 16'h0200, 16'h0030, 16'h002E, 1));
        vecs.push_back(mk("bltz_ffff",  1, 0, 16'h001A, 4'b0110, 16'hFFFF, 0, 16'h0210, 16'h001C, 16'h001A, 1));
        vecs.push_back(idle(16'h0010));
        foreach (vecs[i]) step(vecs[i]);

        // Saturation: three taken at one PC, then not-taken steps back down.
        for (int i = 0; i < 3; i++)
            step(mk("sat_t", 1, 0, 16'h0014, 4'b0100, 16'h0000, 1, 16'h0300, 16'h0016, 16'h0014, 1));
        step(mk("sat_nt1", 1, 0, 16'h0014, 4'b0100, 16'h0001, 1, 16'h0300, 16'h0016, 16'h0014, 0));
        step(idle(16'h0014));
        chk("sat_after_nt1", {31'b0, if_pred_taken}, 32'd1);
        step(mk("sat_nt2", 1, 0, 16'h0014, 4'b0100, 16'h0001, 0, 16'h0300, 16'h0016, 16'h0014, 0));
        step(idle(16'h0014));
        chk("sat_after_nt2", {31'b0, if_pred_taken}, 32'd0);

        // Branch held under stall for a random 3..5 cycles resolves once.
        begin
            int n_stall;
            n_stall = $urandom_range(5, 3);
            for (int i = 0; i < n_stall; i++)
                step(mk("stalled", 1, 1, 16'h0018, 4'b0100, 16'h0000, 0, 16'h0400, 16'h001A, 16'h0018, 1));
            step(mk("stall_rel", 1, 0, 16'h0018, 4'b0100, 16'h0000, 0, 16'h0400, 16'h001A, 16'h0018, 1));
            step(idle(16'h0018));
            chk("stall_one_update", {31'b0, if_pred_taken}, 32'd1);
        end

        // Random operand values on a not-taken-predicted BNEZ.
        for (int i = 0; i < 4; i++) begin
            logic [15:0] r;
            r = 16'($urandom_range(65535, 0));
            step(mk("rand_bnez", 1, 0, 16'h001E, 4'b0101, r, 0, 16'h0500, 16'h0020, 16'h001E, r != 16'h0));
        end

        // Reset with a mispredicting branch; table must be back at weak-NT.
        do_reset();

        // Five resolves after reset: the 2-bit statistics counter saturates at 3.
        for (int i = 0; i < 5; i++)
            step(mk("cnt_sat", 1, 0, 16'h0040, 4'b1000, 16'h0000, 0, 16'h0600, 16'h0042, 16'h0010, 1));
        chk("cnt2_brch_sat", {30'b0, brch_cnt2}, 32'd3);
        chk("cnt16_brch", {16'b0, brch_cnt}, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
